// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style 4-bit LCD byte writer: FSM states,
// default timing (50 MHz clk cycles), init nibbles and command decode helpers.
package lcd_pkg;

  localparam int unsigned CNT_W = 20;

  localparam int unsigned T_PWR_DEF   = 750000;
  localparam int unsigned T_INIT1_DEF = 205000;
  localparam int unsigned T_INIT2_DEF = 5000;
  localparam int unsigned T_CMD_DEF   = 2000;
  localparam int unsigned T_CLR_DEF   = 82000;
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_EPW_DEF   = 12;
  localparam int unsigned T_HOLD_DEF  = 1;
  localparam int unsigned T_GAP_DEF   = 50;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_HOME_MASK = 8'hFE;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_SETUP,
    INIT_PULSE,
    INIT_HOLD,
    INIT_WAIT,
    IDLE,
    HI_SETUP,
    HI_PULSE,
    HI_HOLD,
    GAP,
    LO_SETUP,
    LO_PULSE,
    LO_HOLD,
    BYTE_WAIT
  } state_e;

  // Clear and return-home need the long post-command wait; 0x03 is a home alias.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || ((data & CMD_HOME_MASK) == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte request channel into the LCD writer: valid/ready with rs and data payload.
interface lcd_byte_writer_if;

  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_rs,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_rs,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter: a load of N-1 makes done assert after exactly N cycles.
// Holds at zero once expired; reset preloads RST_VAL.
module lcd_delay_timer #(
  parameter int unsigned   W       = 20,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign done  = (cnt_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// Power-on init plus byte writes to a 4-bit LCD bus; every output is registered.
// Accepts one byte in IDLE only; in_ready returns 2*(setup+pulse+hold)+gap+wait+1 cycles later.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWR   = T_PWR_DEF,
  parameter int unsigned T_INIT1 = T_INIT1_DEF,
  parameter int unsigned T_INIT2 = T_INIT2_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF,
  parameter int unsigned T_CLR   = T_CLR_DEF,
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_EPW   = T_EPW_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  lcd_byte_writer_if.slave   io,
  output logic               init_done,
  output logic               sf_e,
  output logic               lcd_e,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic [3:0]         lcd_d
);

  localparam logic [CNT_W-1:0] LD_PWR   = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] LD_INIT1 = CNT_W'(T_INIT1 - 1);
  localparam logic [CNT_W-1:0] LD_INIT2 = CNT_W'(T_INIT2 - 1);
  localparam logic [CNT_W-1:0] LD_CMD   = CNT_W'(T_CMD - 1);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(T_CLR - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EPW   = CNT_W'(T_EPW - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [3:0]       lcd_d_q, lcd_d_d;
  logic             in_ready_q, in_ready_d;
  logic             init_done_q, init_done_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;
  logic             accept;

  lcd_delay_timer #(
    .W       (CNT_W),
    .RST_VAL (LD_PWR)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .done     (tmr_done)
  );

  assign accept = io.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_q)
      PWR_WAIT: if (tmr_done) begin
        state_d  = INIT_SETUP;
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
      INIT_SETUP: if (tmr_done) begin
        state_d  = INIT_PULSE;
        tmr_load = 1'b1;
        tmr_val  = LD_EPW;
      end
      INIT_PULSE: if (tmr_done) begin
        state_d  = INIT_HOLD;
        tmr_load = 1'b1;
        tmr_val  = LD_HOLD;
      end
      INIT_HOLD: if (tmr_done) begin
        state_d  = INIT_WAIT;
        tmr_load = 1'b1;
        case (idx_q)
          2'd0:    tmr_val = LD_INIT1;
          2'd1:    tmr_val = LD_INIT2;
          default: tmr_val = LD_CMD;
        endcase
      end
      INIT_WAIT: if (tmr_done) begin
        if (idx_q == 2'd3) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end else begin
          state_d  = INIT_SETUP;
          idx_d    = idx_q + 2'd1;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
        end
      end
      IDLE: if (accept) begin
        state_d  = HI_SETUP;
        rs_d     = io.in_rs;
        data_d   = io.in_data;
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
      HI_SETUP: if (tmr_done) begin
        state_d  = HI_PULSE;
        tmr_load = 1'b1;
        tmr_val  = LD_EPW;
      end
      HI_PULSE: if (tmr_done) begin
        state_d  = HI_HOLD;
        tmr_load = 1'b1;
        tmr_val  = LD_HOLD;
      end
      HI_HOLD: if (tmr_done) begin
        state_d  = GAP;
        tmr_load = 1'b1;
        tmr_val  = LD_GAP;
      end
      GAP: if (tmr_done) begin
        state_d  = LO_SETUP;
        tmr_load = 1'b1;
        tmr_val  = LD_SETUP;
      end
      LO_SETUP: if (tmr_done) begin
        state_d  = LO_PULSE;
        tmr_load = 1'b1;
        tmr_val  = LD_EPW;
      end
      LO_PULSE: if (tmr_done) begin
        state_d  = LO_HOLD;
        tmr_load = 1'b1;
        tmr_val  = LD_HOLD;
      end
      LO_HOLD: if (tmr_done) begin
        state_d  = BYTE_WAIT;
        tmr_load = 1'b1;
        tmr_val  = is_slow_cmd(rs_q, data_q) ? LD_CLR : LD_CMD;
      end
      BYTE_WAIT: if (tmr_done) begin
        state_d = IDLE;
      end
      default: begin
        state_d  = PWR_WAIT;
        idx_d    = '0;
        tmr_load = 1'b1;
        tmr_val  = LD_PWR;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    lcd_e_d    = 1'b0;
    lcd_rs_d   = 1'b0;
    lcd_d_d    = 4'h0;
    in_ready_d = (state_q == IDLE) && (state_d == IDLE);
    case (state_d)
      INIT_SETUP, INIT_HOLD: begin
        lcd_d_d = (idx_d == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
      end
      INIT_PULSE: begin
        lcd_d_d = (idx_d == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
        lcd_e_d = 1'b1;
      end
      HI_SETUP, HI_HOLD: begin
        lcd_d_d  = data_d[7:4];
        lcd_rs_d = rs_d;
      end
      HI_PULSE: begin
        lcd_d_d  = data_d[7:4];
        lcd_rs_d = rs_d;
        lcd_e_d  = 1'b1;
      end
      GAP: begin
        lcd_rs_d = rs_d;
      end
      LO_SETUP, LO_HOLD: begin
        lcd_d_d  = data_d[3:0];
        lcd_rs_d = rs_d;
      end
      LO_PULSE: begin
        lcd_d_d  = data_d[3:0];
        lcd_rs_d = rs_d;
        lcd_e_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PWR_WAIT;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_d_q     <= 4'h0;
      in_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_d_q     <= lcd_d_d;
      in_ready_q  <= in_ready_d;
      init_done_q <= init_done_d;
    end
  end

  a_idle_timer_expired: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE) |-> (tmr_value == '0));

  assign io.in_ready = in_ready_q;
  assign init_done   = init_done_q;
  assign lcd_e       = lcd_e_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_d       = lcd_d_q;
  assign lcd_rw      = 1'b0;
  assign sf_e        = 1'b1;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Randomized bench for lcd_byte_writer with short timing; expected pulse times,
// nibbles and ready latency come from an arithmetic model of the protocol timing.
module tb_lcd_byte_writer;

  localparam int T_PWR = 20, T_INIT1 = 10, T_INIT2 = 6, T_CMD = 4, T_CLR = 15;
  localparam int S = 2, E = 3, H = 1, G = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_done, sf_e, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_d;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  lcd_byte_writer_if io();

  lcd_byte_writer #(
    .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD), .T_CLR(T_CLR),
    .T_SETUP(S), .T_EPW(E), .T_HOLD(H), .T_GAP(G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (io),
    .init_done (init_done),
    .sf_e      (sf_e),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_d     (lcd_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  // Pulse monitor: each completed E pulse is logged with its rise cycle, nibble,
  // rs and whether bus/rs stayed stable over setup, pulse and hold with exact widths.
  int         p_cyc[$];
  logic [3:0] p_d[$];
  logic       p_rs[$];
  logic       p_ok[$];
  logic [3:0] hd[0:E+S];
  logic       hr[0:E+S];
  logic       he[0:E+S];

  always @(negedge clk) begin
    bit ok;
    for (int i = E + S; i > 0; i--) begin
      hd[i] = hd[i-1];
      hr[i] = hr[i-1];
      he[i] = he[i-1];
    end
    hd[0] = lcd_d;
    hr[0] = lcd_rs;
    he[0] = lcd_e;
    if (he[0] === 1'b0 && he[1] === 1'b1) begin
      ok = 1'b1;
      for (int i = 1; i <= E; i++) if (he[i] !== 1'b1) ok = 1'b0;
      for (int i = E + 1; i <= E + S; i++) if (he[i] !== 1'b0) ok = 1'b0;
      for (int i = 0; i <= E + S; i++) if (hd[i] !== hd[1] || hr[i] !== hr[1]) ok = 1'b0;
      p_cyc.push_back(cyc - E);
      p_d.push_back(hd[1]);
      p_rs.push_back(hr[1]);
      p_ok.push_back(ok);
    end
  end

  task automatic clear_pulses();
    p_cyc.delete();
    p_d.delete();
    p_rs.delete();
    p_ok.delete();
  endtask

  task automatic check_pulse(input string tag, input bit chk_cyc, input int exp_cyc,
                             input logic [3:0] exp_d, input logic exp_rs);
    if (p_cyc.size() == 0) begin
      check({tag, "_present"}, 0, 1);
    end else begin
      int c = p_cyc.pop_front();
      if (chk_cyc) check({tag, "_rise_cycle"}, c, exp_cyc);
      check({tag, "_nibble"}, p_d.pop_front(), exp_d);
      check({tag, "_rs"}, p_rs.pop_front(), exp_rs);
      check({tag, "_stable"}, p_ok.pop_front(), 1);
    end
  endtask

  task automatic wait_ready(output int c);
    int n = 0;
    while (io.in_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (io.in_ready !== 1'b1) check("ready_timeout", io.in_ready, 1);
    c = cyc;
  endtask

  function automatic int exp_latency(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLR : T_CMD;
    return 2 * (S + E + H) + G + w + 1;
  endfunction

  // Init model: four nibbles 3,3,3,2 spaced by pulse+hold+wait+setup after the power wait.
  task automatic check_init(input int rel);
    int n = 0;
    int t;
    int w[4];
    w = '{T_INIT1, T_INIT2, T_CMD, T_CMD};
    while (init_done !== 1'b1 && n < 1000) begin
      check("ready_during_init", io.in_ready, 0);
      @(negedge clk);
      n++;
    end
    t = T_PWR + S;
    for (int i = 0; i < 4; i++) begin
      check_pulse("init", 1'b1, rel + t, (i == 3) ? 4'h2 : 4'h3, 1'b0);
      t += E + H + w[i] + S;
    end
    check("init_done_cycle", cyc - rel, t - S);
    check("init_extra_pulses", p_cyc.size(), 0);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    int c, acc;
    wait_ready(c);
    io.in_valid = 1'b1;
    io.in_rs    = rs;
    io.in_data  = d;
    @(negedge clk);
    acc = cyc;
    io.in_valid = 1'b0;
    io.in_rs    = 1'($urandom);
    io.in_data  = 8'($urandom);
    wait_ready(c);
    check("ready_latency", c - acc, exp_latency(rs, d));
    check_pulse("hi", 1'b1, acc + S, d[7:4], rs);
    check_pulse("lo", 1'b1, acc + 2 * S + E + H + G, d[3:0], rs);
  endtask

  task automatic stream(input int k);
    logic       q_rs[$];
    logic [7:0] q_d[$];
    int got = 0;
    int n = 0;
    int c;
    wait_ready(c);
    clear_pulses();
    while (got < k && n < 3000) begin
      io.in_valid = 1'b1;
      io.in_rs    = 1'($urandom);
      io.in_data  = 8'($urandom);
      if (io.in_ready === 1'b1) begin
        q_rs.push_back(io.in_rs);
        q_d.push_back(io.in_data);
        got++;
      end
      @(negedge clk);
      n++;
    end
    io.in_valid = 1'b0;
    check("stream_accepts", got, k);
    wait_ready(c);
    check("stream_pulse_count", p_cyc.size(), 2 * got);
    for (int i = 0; i < got; i++) begin
      check_pulse("stream_hi", 1'b0, 0, q_d[i][7:4], q_rs[i]);
      check_pulse("stream_lo", 1'b0, 0, q_d[i][3:0], q_rs[i]);
    end
  endtask

  initial begin
    int rel, c, acc;
    rst         = 1'b1;
    io.in_valid = 1'b0;
    io.in_rs    = 1'b0;
    io.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", io.in_ready, 0);
    check("rst_init_done", init_done, 0);
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_rw", lcd_rw, 0);
    check("rst_lcd_d", lcd_d, 0);
    check("rst_sf_e", sf_e, 1);
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    clear_pulses();
    check_init(rel);

    send(1'b1, 8'h41);
    send(1'b0, 8'h01);
    send(1'b0, 8'h41);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    send(1'b1, 8'h01);
    send(1'b0, 8'h00);
    send(1'b0, 8'h04);
    for (int i = 0; i < 8; i++) begin
      logic       r;
      logic [7:0] d;
      r = 1'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r = 1'b0;
        d = 8'($urandom_range(1, 3));
      end
      send(r, d);
    end

    stream(5);

    // Reset in the middle of the low-nibble pulse.
    wait_ready(c);
    io.in_valid = 1'b1;
    io.in_rs    = 1'b1;
    io.in_data  = 8'hC7;
    @(negedge clk);
    acc = cyc;
    io.in_valid = 1'b0;
    repeat (2 * S + E + H + G + 1) @(negedge clk);
    check("mid_lo_pulse_e", lcd_e, 1);
    check("mid_lo_pulse_d", lcd_d, 4'h7);
    rst = 1'b1;
    @(negedge clk);
    check("abort_lcd_e", lcd_e, 0);
    check("abort_in_ready", io.in_ready, 0);
    check("abort_init_done", init_done, 0);
    check("abort_lcd_d", lcd_d, 0);
    check("abort_lcd_rs", lcd_rs, 0);
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    clear_pulses();
    check_init(rel);
    send(1'b1, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
